// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Register file with write bypass, zero and external-input
//            registers, and a per-register busy scoreboard for RAW hazards.
// Revision : 1.0  initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int EXT_IDX   = 29,
  parameter int EXT_W     = 8,
  parameter int BYPASS    = 1,
  parameter int PROBE_IDX = 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_issueEnable,
  input  logic [ADDR_W-1:0] ctrl_issueReg,
  input  logic [EXT_W-1:0]  ext_data,
  output logic              busy_A,
  output logic              busy_B,
  output logic              ctrl_hazard,
  output logic [ADDR_W:0]   pending_count,
  output logic [DATA_W-1:0] probe
);

  localparam int                C_DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_EXT_IDX   = ADDR_W'(EXT_IDX);
  localparam logic [ADDR_W-1:0] C_PROBE_IDX = ADDR_W'(PROBE_IDX);

  logic [DATA_W-1:0]  r_regs [C_DEPTH];
  logic [C_DEPTH-1:0] r_busy;
  logic [ADDR_W:0]    r_count;

  logic w_wr_en;
  logic w_iss_en;
  logic w_set;
  logic w_clr;

  function automatic logic is_prot(input logic [ADDR_W-1:0] idx);
    return (idx == '0) || (idx == C_EXT_IDX);
  endfunction

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] idx);
    if (idx == '0)
      return '0;
    else if (idx == C_EXT_IDX)
      return DATA_W'(ext_data);
    else if ((BYPASS != 0) && w_wr_en && (ctrl_writeReg == idx))
      return data_writeReg;
    else
      return r_regs[idx];
  endfunction

  // A forwarded value is valid unless a new op re-claims the same register.
  function automatic logic rd_busy(input logic [ADDR_W-1:0] idx);
    if (is_prot(idx))
      return 1'b0;
    else if ((BYPASS != 0) && w_wr_en && (ctrl_writeReg == idx) &&
             !(w_iss_en && (ctrl_issueReg == idx)))
      return 1'b0;
    else
      return r_busy[idx];
  endfunction

  always_comb begin
    w_wr_en  = ctrl_writeEnable && !is_prot(ctrl_writeReg);
    w_iss_en = ctrl_issueEnable && !is_prot(ctrl_issueReg);
    w_set    = w_iss_en && !r_busy[ctrl_issueReg];
    w_clr    = w_wr_en && r_busy[ctrl_writeReg] &&
               !(w_iss_en && (ctrl_issueReg == ctrl_writeReg));
  end

  always_comb begin
    data_readRegA = rd_data(ctrl_readRegA);
    data_readRegB = rd_data(ctrl_readRegB);
    busy_A        = rd_busy(ctrl_readRegA);
    busy_B        = rd_busy(ctrl_readRegB);
    ctrl_hazard   = busy_A | busy_B;
    pending_count = r_count;
    probe         = r_regs[C_PROBE_IDX];
  end

  // Issue is applied after writeback so a same-register issue keeps it busy.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) begin
        r_regs[ctrl_writeReg] <= data_writeReg;
        r_busy[ctrl_writeReg] <= 1'b0;
      end
      if (w_iss_en) begin
        r_busy[ctrl_issueReg] <= 1'b1;
      end
      r_count <= r_count + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed and randomized check of regfile_scoreboard (BYPASS=1/0).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic [4:0]  ctrl_readRegA = '0;
  logic [4:0]  ctrl_readRegB = '0;
  logic        ctrl_issueEnable = 1'b0;
  logic [4:0]  ctrl_issueReg = '0;
  logic [7:0]  ext_data = '0;

  logic [31:0] a_rdA, a_rdB, a_probe, b_rdA, b_rdB, b_probe;
  logic        a_bA, a_bB, a_hz, b_bA, b_bB, b_hz;
  logic [5:0]  a_cnt, b_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clock = ~clock;

  regfile_scoreboard #(.BYPASS(1)) u_byp (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(a_rdA), .data_readRegB(a_rdB),
    .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
    .ext_data(ext_data), .busy_A(a_bA), .busy_B(a_bB), .ctrl_hazard(a_hz),
    .pending_count(a_cnt), .probe(a_probe)
  );

  regfile_scoreboard #(.BYPASS(0)) u_nobyp (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(b_rdA), .data_readRegB(b_rdB),
    .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg),
    .ext_data(ext_data), .busy_A(b_bA), .busy_B(b_bB), .ctrl_hazard(b_hz),
    .pending_count(b_cnt), .probe(b_probe)
  );

  function automatic bit prot(input logic [4:0] idx);
    return (idx == 5'd0) || (idx == 5'd29);
  endfunction

  // Behavioural reference: architectural register contents and busy flags.
  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (ctrl_writeEnable && !prot(ctrl_writeReg)) begin
        m_regs[ctrl_writeReg] = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_issueEnable && !prot(ctrl_issueReg))
        m_busy[ctrl_issueReg] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (idx == 5'd29) return {24'd0, ext_data};
    if (byp && ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] idx, input bit byp);
    if (prot(idx)) return 32'd0;
    if (byp && ctrl_writeEnable && ctrl_writeReg == idx &&
        !(ctrl_issueEnable && ctrl_issueReg == idx)) return 32'd0;
    return {31'd0, m_busy[idx]};
  endfunction

  function automatic logic [31:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("byp_rdA", a_rdA, exp_rd(ctrl_readRegA, 1'b1));
      cmp("byp_rdB", a_rdB, exp_rd(ctrl_readRegB, 1'b1));
      cmp("byp_busyA", {31'd0, a_bA}, exp_busy(ctrl_readRegA, 1'b1));
      cmp("byp_busyB", {31'd0, a_bB}, exp_busy(ctrl_readRegB, 1'b1));
      cmp("byp_hazard", {31'd0, a_hz},
          exp_busy(ctrl_readRegA, 1'b1) | exp_busy(ctrl_readRegB, 1'b1));
      cmp("byp_count", {26'd0, a_cnt}, exp_cnt());
      cmp("byp_probe", a_probe, m_regs[1]);
      cmp("nob_rdA", b_rdA, exp_rd(ctrl_readRegA, 1'b0));
      cmp("nob_rdB", b_rdB, exp_rd(ctrl_readRegB, 1'b0));
      cmp("nob_busyA", {31'd0, b_bA}, exp_busy(ctrl_readRegA, 1'b0));
      cmp("nob_busyB", {31'd0, b_bB}, exp_busy(ctrl_readRegB, 1'b0));
      cmp("nob_hazard", {31'd0, b_hz},
          exp_busy(ctrl_readRegA, 1'b0) | exp_busy(ctrl_readRegB, 1'b0));
      cmp("nob_count", {26'd0, b_cnt}, exp_cnt());
      cmp("nob_probe", b_probe, m_regs[1]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_writeEnable = 1'b0;
    ctrl_issueEnable = 1'b0;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [4:0] pick();
    logic [4:0] r;
    r = 5'($urandom_range(0, 9));
    if (r == 5'd9) r = 5'd29;
    return r;
  endfunction

  initial begin
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    sample();
    cmp("rst_rdA", a_rdA, 32'd0);
    cmp("rst_count", {26'd0, a_cnt}, 32'd0);
    @(posedge clock); #1;
    ctrl_reset = 1'b0;

    // Basic write then read
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
    step(); idle();
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0;
    sample();
    cmp("lit_r5", a_rdA, 32'hDEADBEEF);
    cmp("lit_r0", a_rdB, 32'd0);

    // Protected registers ignore writes
    step();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
    step();
    ctrl_writeReg = 5'd29; ext_data = 8'hA5;
    step(); idle();
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd29;
    sample();
    cmp("lit_w_r0", a_rdA, 32'd0);
    cmp("lit_ext", a_rdB, 32'h000000A5);
    cmp("lit_ext_nob", b_rdB, 32'h000000A5);

    // Same-cycle bypass vs. old value; probe shows stored value only
    step();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h55; ctrl_readRegA = 5'd7;
    sample();
    cmp("lit_byp", a_rdA, 32'h55);
    cmp("lit_byp_busy", {31'd0, a_bA}, 32'd0);
    cmp("lit_nobyp", b_rdA, 32'd0);
    step();
    ctrl_writeReg = 5'd1; data_writeReg = 32'hABCD; ctrl_readRegA = 5'd1;
    sample();
    cmp("lit_probe_old", a_probe, 32'd0);
    step(); idle();
    sample();
    cmp("lit_probe_new", a_probe, 32'hABCD);

    // Scoreboard issue / writeback
    step();
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd3;
    step();
    ctrl_issueReg = 5'd4;
    step(); idle();
    ctrl_readRegA = 5'd3;
    sample();
    cmp("lit_cnt2", {26'd0, a_cnt}, 32'd2);
    cmp("lit_busyA", {31'd0, a_bA}, 32'd1);
    cmp("lit_hazard", {31'd0, a_hz}, 32'd1);
    step();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h33;
    step(); idle();
    sample();
    cmp("lit_cnt1", {26'd0, a_cnt}, 32'd1);
    cmp("lit_busyA_clr", {31'd0, a_bA}, 32'd0);

    // Issue and writeback to the same register in one cycle
    step();
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd6;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd6; data_writeReg = 32'h66;
    step(); idle();
    ctrl_readRegA = 5'd6;
    sample();
    cmp("lit_r6_busy", {31'd0, a_bA}, 32'd1);
    cmp("lit_r6_cnt", {26'd0, a_cnt}, 32'd2);
    cmp("lit_r6_data", a_rdA, 32'h66);

    // Asynchronous reset between edges
    step();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd8; data_writeReg = 32'h88;
    step(); idle();
    ctrl_issueEnable = 1'b1; ctrl_issueReg = 5'd8;
    step(); idle();
    ctrl_readRegA = 5'd8;
    #1 ctrl_reset = 1'b1;
    #1;
    cmp("lit_ar_busy", {31'd0, a_bA}, 32'd0);
    cmp("lit_ar_cnt", {26'd0, a_cnt}, 32'd0);
    cmp("lit_ar_r8", a_rdA, 32'd0);
    step();
    ctrl_reset = 1'b0;

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      ctrl_writeEnable = 1'($urandom_range(0, 1));
      ctrl_writeReg    = pick();
      data_writeReg    = $urandom;
      ctrl_issueEnable = ($urandom_range(0, 2) == 0);
      ctrl_issueReg    = (($urandom_range(0, 3) == 0) ? ctrl_writeReg : pick());
      ctrl_readRegA    = (($urandom_range(0, 3) == 0) ? ctrl_writeReg : pick());
      ctrl_readRegB    = (($urandom_range(0, 3) == 0) ? ctrl_issueReg : pick());
      ext_data         = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 ctrl_reset = 1'b1;
        #1 ctrl_reset = 1'b0;
      end
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
